// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  data_memory_pkg
//  Shared load/store width encodings (RISC-V funct3) for the data memory.
//  Revision: 1.0
// ============================================================================
package data_memory_pkg;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/data_memory_load_extend.sv
`default_nettype none
// ============================================================================
//  load_extend
//  Selects the addressed byte/halfword of a word and sign/zero-extends it.
//  Revision: 1.0
// ============================================================================
module load_extend
   import data_memory_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [2:0]  mem_width,
   input  logic [1:0]  lane,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rd_word[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (mem_width)
         MEM_B:   data = {{24{byte_sel[7]}}, byte_sel};
         MEM_BU:  data = {24'h0, byte_sel};
         MEM_H:   data = {{16{half_sel[15]}}, half_sel};
         MEM_HU:  data = {16'h0, half_sel};
         // LW and the unused encodings all return the whole word
         default: data = rd_word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  data_memory
//  Byte-addressable little-endian data memory, combinational read, async clear.
//  Revision: 1.0
// ============================================================================
module data_memory
   import data_memory_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS  = 128,
   parameter logic [31:0] DISPLAY_ADDR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        write_enable,
   input  logic [2:0]  mem_width,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic [31:0] address_100
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [AW-1:0] DISP_IDX = DISPLAY_ADDR[AW+1:2];

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [31:0]   mem_d [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic [3:0]    byte_en;
   logic [31:0]   wr_aligned;
   logic          unused_addr_bits;

   assign word_idx         = addr[AW+1:2];
   assign lane             = addr[1:0];
   assign unused_addr_bits = ^addr[31:AW+2];

   // Replicating the store data lets each lane simply pick its own slice
   always_comb begin
      byte_en    = 4'b0000;
      wr_aligned = write_data;
      case (mem_width)
         MEM_B, MEM_BU: begin
            byte_en    = 4'b0001 << lane;
            wr_aligned = {4{write_data[7:0]}};
         end
         MEM_H, MEM_HU: begin
            byte_en    = addr[1] ? 4'b1100 : 4'b0011;
            wr_aligned = {2{write_data[15:0]}};
         end
         MEM_W: begin
            byte_en    = 4'b1111;
            wr_aligned = write_data;
         end
         default: byte_en = 4'b0000;
      endcase
   end

   always_comb begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (write_enable) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem_d[word_idx][8*b +: 8] = wr_aligned[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   load_extend u_load_extend (
      .rd_word   (mem_q[word_idx]),
      .mem_width (mem_width),
      .lane      (lane),
      .data      (read_data)
   );

   assign address_100 = mem_q[DISP_IDX];

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  tb_data_memory
//  Table-driven directed bench for data_memory.
//  Revision: 1.0
// ============================================================================
module tb_data_memory;
   import data_memory_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        write_enable;
   logic [2:0]  mem_width;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic [31:0] address_100;

   int n_vec;
   int n_err;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  w;
      logic [31:0] a;
      logic [31:0] d;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vq[$];

   data_memory #(.DEPTH_WORDS(128), .DISPLAY_ADDR(32'h0000_0100)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (write_enable),
      .mem_width    (mem_width),
      .addr         (addr),
      .write_data   (write_data),
      .read_data    (read_data),
      .address_100  (address_100)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic apply(input logic we, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      write_enable = we;
      mem_width    = w;
      addr         = a;
      write_data   = d;
      #1;
   endtask

   task automatic add(input string name, input logic we, input logic [2:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic chk, input logic [31:0] exp);
      vec_t v;
      v.name = name; v.we = we; v.w = w; v.a = a; v.d = d; v.chk = chk; v.exp = exp;
      vq.push_back(v);
   endtask

   task automatic build_word(input logic [31:0] i);
      add("sw_f0",  1'b1, MEM_W,  i,     32'hF0F0_F0F0, 1'b0, 32'h0);
      add("lw_f0",  1'b0, MEM_W,  i,     32'h0F0F_0F0F, 1'b1, 32'hF0F0_F0F0);
      add("lb_f0",  1'b0, MEM_B,  i,     32'h0F0F_0F0F, 1'b1, 32'hFFFF_FFF0);
      add("lh_f0",  1'b0, MEM_H,  i,     32'h0F0F_0F0F, 1'b1, 32'hFFFF_F0F0);
      add("lbu_f0", 1'b0, MEM_BU, i,     32'h0F0F_0F0F, 1'b1, 32'h0000_00F0);
      add("lhu_f0", 1'b0, MEM_HU, i,     32'h0F0F_0F0F, 1'b1, 32'h0000_F0F0);
      add("sw_0f",  1'b1, MEM_W,  i,     32'h0F0F_0F0F, 1'b0, 32'h0);
      add("lw_0f",  1'b0, MEM_W,  i,     32'h0,         1'b1, 32'h0F0F_0F0F);
      add("lb_0f",  1'b0, MEM_B,  i,     32'h0,         1'b1, 32'h0000_000F);
      add("lh_0f",  1'b0, MEM_H,  i,     32'h0,         1'b1, 32'h0000_0F0F);
      add("lbu_0f", 1'b0, MEM_BU, i,     32'h0,         1'b1, 32'h0000_000F);
      add("lhu_0f", 1'b0, MEM_HU, i,     32'h0,         1'b1, 32'h0000_0F0F);
      add("sw_z",   1'b1, MEM_W,  i,     32'h0,         1'b0, 32'h0);
      add("sb0",    1'b1, MEM_B,  i,     32'hFFFF_FF89, 1'b0, 32'h0);
      add("sb1",    1'b1, MEM_B,  i + 1, 32'hFFFF_FF67, 1'b0, 32'h0);
      add("sb2",    1'b1, MEM_BU, i + 2, 32'hFFFF_FF45, 1'b0, 32'h0);
      add("sb3",    1'b1, MEM_B,  i + 3, 32'hFFFF_FF23, 1'b0, 32'h0);
      add("lw_sb",  1'b0, MEM_W,  i,     32'h0,         1'b1, 32'h2345_6789);
      add("lb3_sb", 1'b0, MEM_B,  i + 3, 32'h0,         1'b1, 32'h0000_0023);
      add("lbu_sb", 1'b0, MEM_BU, i,     32'h0,         1'b1, 32'h0000_0089);
      add("lb0_sb", 1'b0, MEM_B,  i,     32'h0,         1'b1, 32'hFFFF_FF89);
      add("sw_z2",  1'b1, MEM_W,  i,     32'h0,         1'b0, 32'h0);
      add("sh2",    1'b1, MEM_H,  i + 2, 32'hABCD_8001, 1'b0, 32'h0);
      add("lw_sh",  1'b0, MEM_W,  i,     32'h0,         1'b1, 32'h8001_0000);
      add("lh_sh",  1'b0, MEM_H,  i + 2, 32'h0,         1'b1, 32'hFFFF_8001);
      add("lhu_sh", 1'b0, MEM_HU, i + 2, 32'h0,         1'b1, 32'h0000_8001);
   endtask

   task automatic run_table();
      foreach (vq[k]) begin
         apply(vq[k].we, vq[k].w, vq[k].a, vq[k].d);
         if (vq[k].chk) check($sformatf("%s@%0h", vq[k].name, vq[k].a), read_data, vq[k].exp);
      end
      vq.delete();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      write_enable = 1'b0;
      mem_width = MEM_W;
      addr = '0;
      write_data = '0;
      #1;
      check("reset_rd",   read_data,   32'h0);
      check("reset_a100", address_100, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Word 0: main table plus lane, invalid-width and aliasing corners
      build_word(32'h0);
      add("sw_mix",   1'b1, MEM_W,  32'h0,         32'h8081_7F80, 1'b0, 32'h0);
      add("lb1",      1'b0, MEM_B,  32'h1,         32'h0,         1'b1, 32'h0000_007F);
      add("lb2",      1'b0, MEM_B,  32'h2,         32'h0,         1'b1, 32'hFFFF_FF81);
      add("lbu3",     1'b0, MEM_BU, 32'h3,         32'h0,         1'b1, 32'h0000_0080);
      add("lh1",      1'b0, MEM_H,  32'h1,         32'h0,         1'b1, 32'h0000_7F80);
      add("lhu3",     1'b0, MEM_HU, 32'h3,         32'h0,         1'b1, 32'h0000_8081);
      add("lh3",      1'b0, MEM_H,  32'h3,         32'h0,         1'b1, 32'hFFFF_8081);
      add("rd_inv",   1'b0, 3'b111, 32'h2,         32'h0,         1'b1, 32'h8081_7F80);
      add("wr_inv",   1'b1, 3'b011, 32'h0,         32'hFFFF_FFFF, 1'b0, 32'h0);
      add("chk_inv",  1'b0, MEM_W,  32'h0,         32'h0,         1'b1, 32'h8081_7F80);
      add("wr_inv6",  1'b1, 3'b110, 32'h1,         32'hFFFF_FFFF, 1'b0, 32'h0);
      add("we0",      1'b0, MEM_W,  32'h0,         32'h1234_5678, 1'b0, 32'h0);
      add("chk_we0",  1'b0, MEM_W,  32'h0,         32'h1234_5678, 1'b1, 32'h8081_7F80);
      add("alias_rd", 1'b0, MEM_W,  32'h0000_0200, 32'h0,         1'b1, 32'h8081_7F80);
      add("alias_sb", 1'b1, MEM_B,  32'hFFFF_FE01, 32'h0000_0055, 1'b0, 32'h0);
      add("alias_ck", 1'b0, MEM_W,  32'h0,         32'h0,         1'b1, 32'h8081_5580);
      run_table();

      for (int i = 4; i <= 196; i += 4) begin
         build_word(i);
         run_table();
      end

      // Display word: visible right after the writing edge, whatever addr is
      apply(1'b1, MEM_W, 32'h0000_0100, 32'hDEAD_BEEF);
      check("a100_pre", address_100, 32'h0);
      @(posedge clk);
      #1;
      check("a100_sw", address_100, 32'hDEAD_BEEF);
      apply(1'b1, MEM_BU, 32'h0000_0101, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("a100_sb", address_100, 32'hDEAD_00EF);
      apply(1'b1, MEM_W, 32'h0000_0104, 32'h1111_1111);
      @(posedge clk);
      #1;
      check("a100_nbr", address_100, 32'hDEAD_00EF);

      // Reset mid-cycle clears immediately and blocks writes
      apply(1'b0, MEM_W, 32'h0000_0100, 32'h0);
      check("pre_rst_rd", read_data, 32'hDEAD_00EF);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_rd",   read_data,   32'h0);
      check("rst_a100", address_100, 32'h0);
      write_enable = 1'b1;
      write_data   = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      check("rst_we_a100", address_100, 32'h0);
      check("rst_we_rd",   read_data,   32'h0);
      @(negedge clk);
      write_enable = 1'b0;
      rst_n = 1'b1;
      #1;
      check("post_rst_a100", address_100, 32'h0);
      apply(1'b1, MEM_W, 32'h0000_0100, 32'h1122_3344);
      apply(1'b0, MEM_HU, 32'h0000_0102, 32'h0);
      check("post_rst_lhu", read_data,   32'h0000_1122);
      check("post_rst_a100", address_100, 32'h1122_3344);
      apply(1'b0, MEM_W, 32'h0000_0004, 32'h0);
      check("post_rst_w1", read_data, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
